weight_pingpong_buffer: RTL and testbench

Double-banked (ping-pong) weight store between the DMA write stream and the conv engine read port. DMA fills one bank while the engine reads the other, so weight load overlaps compute. Generalises the single-bank buffer with parametrised width and depth, per-bank fill tracking, and simultaneous write/read.

---
 rtl/wbuf_pkg.sv | 20 ++
 rtl/wbuf_bank_ram.sv | 29 ++
 rtl/weight_pingpong_buffer.sv | 146 ++++++++++++++
 tb/tb_weight_pingpong_buffer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wbuf_pkg.sv
// Shared types for the weight ping-pong buffer: per-bank state encoding and
// the even-parity helper used when parity protection is built in.
package wbuf_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2,
    READING = 2'd3
  } bank_state_e;

  // Widest word the parity helper accepts; narrower words are zero-extended,
  // which leaves the XOR reduction unchanged.
  localparam int PAR_MAX_W = 512;

  function automatic logic parity(input logic [PAR_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/wbuf_bank_ram.sv
// One weight bank: simple dual-port RAM, one write port and one registered
// read port. The read register clears on reset so the buffer output starts at 0.
module wbuf_bank_ram #(
  parameter int WIDTH     = 64,
  parameter int DEPTH     = 1024,
  parameter int ADDR_SIZE = 10
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 we,
  input  logic [ADDR_SIZE-1:0] waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic                 re,
  input  logic [ADDR_SIZE-1:0] raddr,
  output logic [WIDTH-1:0]     rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rstn)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/weight_pingpong_buffer.sv
// Double-banked weight store: DMA fills one bank while the conv engine reads
// the other. Define WBUF_PARITY_EN to store and check an even-parity bit per word.
module weight_pingpong_buffer
  import wbuf_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 1024,
  parameter int ADDR_SIZE  = 10
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  w_valid,
  input  logic                  w_last,
  output logic                  w_ready,
  input  logic                  conv_en,
  input  logic                  w_done,
  input  logic [ADDR_SIZE-1:0]  weight_addr,
  input  logic                  w_addr_vld,
  output logic [DATA_WIDTH-1:0] weight_data,
  output logic                  weight_data_vld,
  output logic [1:0]            bank_full,
  output logic                  rd_bank,
  output logic [ADDR_SIZE:0]    blk_words,
  output logic                  ovf_err,
  output logic                  parity_err
);

`ifdef WBUF_PARITY_EN
  localparam int RAM_W = DATA_WIDTH + 1;
`else
  localparam int RAM_W = DATA_WIDTH;
`endif

  bank_state_e          state   [2];
  bank_state_e          state_n [2];
  logic [ADDR_SIZE:0]   cnt     [2];
  logic [ADDR_SIZE:0]   cnt_n   [2];
  logic                 wr_bank, wr_bank_n, rd_bank_n;
  logic [ADDR_SIZE-1:0] wr_ptr, wr_ptr_n;
  logic [ADDR_SIZE:0]   blk_words_n;
  logic                 ovf_n, ready_n;
  logic                 accept, rd_en, at_end;
  logic                 rd_sel_p1, vld_p1;
  logic [RAM_W-1:0]     wword, rdata0, rdata1, rword;

  assign accept = w_valid && w_ready;
  assign at_end = (wr_ptr == ADDR_SIZE'(DEPTH - 1));
  assign rd_en  = w_addr_vld && (state[rd_bank] == READING);

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    wr_bank_n   = wr_bank;
    rd_bank_n   = rd_bank;
    wr_ptr_n    = wr_ptr;
    blk_words_n = blk_words;
    ovf_n       = ovf_err;
    if (accept) begin
      if (state[wr_bank] == EMPTY) state_n[wr_bank] = FILLING;
      // A full bank without w_last is closed as if the beat were last.
      if (w_last || at_end) begin
        cnt_n[wr_bank]   = (ADDR_SIZE+1)'(wr_ptr) + 1'b1;
        state_n[wr_bank] = FULL;
        wr_ptr_n         = '0;
        wr_bank_n        = ~wr_bank;
        if (!w_last) ovf_n = 1'b1;
      end else begin
        wr_ptr_n = wr_ptr + 1'b1;
      end
    end
    if (w_done && (state[rd_bank] == READING)) begin
      state_n[rd_bank] = EMPTY;
      rd_bank_n        = ~rd_bank;
    end
    // conv_en sees rd_bank after any same-cycle w_done release.
    if (conv_en && (state[rd_bank_n] == FULL)) begin
      state_n[rd_bank_n] = READING;
      blk_words_n        = cnt[rd_bank_n];
    end
    ready_n = (state_n[wr_bank_n] == EMPTY) || (state_n[wr_bank_n] == FILLING);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state[0]  <= EMPTY;
      state[1]  <= EMPTY;
      cnt[0]    <= '0;
      cnt[1]    <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_ptr    <= '0;
      w_ready   <= 1'b1;
      blk_words <= '0;
      ovf_err   <= 1'b0;
      vld_p1    <= 1'b0;
      rd_sel_p1 <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      wr_bank   <= wr_bank_n;
      rd_bank   <= rd_bank_n;
      wr_ptr    <= wr_ptr_n;
      w_ready   <= ready_n;
      blk_words <= blk_words_n;
      ovf_err   <= ovf_n;
      vld_p1    <= rd_en;
      if (rd_en) rd_sel_p1 <= rd_bank;
    end
  end

`ifdef WBUF_PARITY_EN
  assign wword = {parity(PAR_MAX_W'(w_data)), w_data};
`else
  assign wword = w_data;
`endif

  wbuf_bank_ram #(.WIDTH(RAM_W), .DEPTH(DEPTH), .ADDR_SIZE(ADDR_SIZE)) u_ram0 (
    .clk(clk), .rstn(rstn),
    .we(accept && !wr_bank), .waddr(wr_ptr), .wdata(wword),
    .re(rd_en && !rd_bank), .raddr(weight_addr), .rdata(rdata0)
  );

  wbuf_bank_ram #(.WIDTH(RAM_W), .DEPTH(DEPTH), .ADDR_SIZE(ADDR_SIZE)) u_ram1 (
    .clk(clk), .rstn(rstn),
    .we(accept && wr_bank), .waddr(wr_ptr), .wdata(wword),
    .re(rd_en && rd_bank), .raddr(weight_addr), .rdata(rdata1)
  );

  // ---- p1: registered RAM read, output select ----
  assign rword           = rd_sel_p1 ? rdata1 : rdata0;
  assign weight_data     = rword[DATA_WIDTH-1:0];
  assign weight_data_vld = vld_p1;
  assign bank_full       = {(state[1] == FULL) || (state[1] == READING),
                            (state[0] == FULL) || (state[0] == READING)};

`ifdef WBUF_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rstn)                                       parity_err <= 1'b0;
    else if (vld_p1 && parity(PAR_MAX_W'(rword)))    parity_err <= 1'b1;
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_weight_pingpong_buffer.sv
// Directed bench for weight_pingpong_buffer (DEPTH=16) with a bank-level
// reference model checked every cycle plus hand-computed spot values.
module tb_weight_pingpong_buffer;
  localparam int DW  = 64;
  localparam int DEP = 16;
  localparam int AW  = 4;
`ifdef WBUF_PARITY_EN
  localparam logic PERR_EXP = 1'b1;
  localparam logic [63:0] W3_EXP = 64'h2;
`else
  localparam logic PERR_EXP = 1'b0;
  localparam logic [63:0] W3_EXP = 64'h3;
`endif

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [DW-1:0] w_data = '0;
  logic          w_valid = 1'b0, w_last = 1'b0, conv_en = 1'b0, w_done = 1'b0;
  logic [AW-1:0] weight_addr = '0;
  logic          w_addr_vld = 1'b0;
  logic          w_ready, weight_data_vld, rd_bank, ovf_err, parity_err;
  logic [DW-1:0] weight_data;
  logic [1:0]    bank_full;
  logic [AW:0]   blk_words;

  always #5 clk = ~clk;

  weight_pingpong_buffer #(.DATA_WIDTH(DW), .DEPTH(DEP), .ADDR_SIZE(AW)) dut (
    .clk(clk), .rstn(rstn), .w_data(w_data), .w_valid(w_valid), .w_last(w_last),
    .w_ready(w_ready), .conv_en(conv_en), .w_done(w_done), .weight_addr(weight_addr),
    .w_addr_vld(w_addr_vld), .weight_data(weight_data), .weight_data_vld(weight_data_vld),
    .bank_full(bank_full), .rd_bank(rd_bank), .blk_words(blk_words),
    .ovf_err(ovf_err), .parity_err(parity_err)
  );

  int checks = 0, errors = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bank states 0=empty 1=filling 2=full 3=reading
  int          m_st [2];
  int          pre_st [2];
  int          m_cnt [2];
  int          m_wr, m_rd, m_ptr, m_blk;
  logic [63:0] m_mem [2][DEP];
  bit          m_bad_mem [2][DEP];
  logic [63:0] m_data;
  bit          m_vld, m_bad, m_ovf, m_perr, m_ready;

  always @(posedge clk) begin
    if (!rstn) begin
      m_st = '{0, 0}; m_cnt = '{0, 0};
      m_wr = 0; m_rd = 0; m_ptr = 0; m_blk = 0;
      m_data = '0; m_vld = 0; m_bad = 0; m_ovf = 0; m_perr = 0; m_ready = 1;
    end else begin
      pre_st = m_st;
      m_perr = m_perr | (m_vld & m_bad);
      if (w_addr_vld && m_st[m_rd] == 3) begin
        m_vld = 1; m_data = m_mem[m_rd][weight_addr]; m_bad = m_bad_mem[m_rd][weight_addr];
      end else begin
        m_vld = 0; m_bad = 0;
      end
      if (w_valid && m_ready) begin
        m_mem[m_wr][m_ptr] = w_data;
        m_bad_mem[m_wr][m_ptr] = 0;
        if (m_st[m_wr] == 0) m_st[m_wr] = 1;
        if (w_last || m_ptr == DEP - 1) begin
          if (!w_last) m_ovf = 1;
          m_cnt[m_wr] = m_ptr + 1;
          m_st[m_wr] = 2;
          m_ptr = 0;
          m_wr = 1 - m_wr;
        end else begin
          m_ptr++;
        end
      end
      if (w_done && pre_st[m_rd] == 3) begin
        m_st[m_rd] = 0;
        m_rd = 1 - m_rd;
      end
      if (conv_en && pre_st[m_rd] == 2) begin
        m_st[m_rd] = 3;
        m_blk = m_cnt[m_rd];
      end
      m_ready = (m_st[m_wr] <= 1);
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("m_w_ready", 64'(w_ready), 64'(m_ready));
      chk("m_bank_full", 64'(bank_full), {62'd0, m_st[1] >= 2, m_st[0] >= 2});
      chk("m_rd_bank", 64'(rd_bank), 64'(m_rd));
      chk("m_blk_words", 64'(blk_words), 64'(m_blk));
      chk("m_ovf_err", 64'(ovf_err), 64'(m_ovf));
      chk("m_parity_err", 64'(parity_err), 64'(m_perr));
      chk("m_data_vld", 64'(weight_data_vld), 64'(m_vld));
      chk("m_weight_data", weight_data, m_data);
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic beat(input logic [63:0] d, input logic last);
    w_data = d; w_valid = 1'b1; w_last = last;
    cyc();
    w_valid = 1'b0; w_last = 1'b0;
  endtask

  task automatic rd(input int a);
    weight_addr = AW'(a); w_addr_vld = 1'b1;
    cyc();
    w_addr_vld = 1'b0;
  endtask

  task automatic pulse(input bit c, input bit d);
    conv_en = c; w_done = d;
    cyc();
    conv_en = 1'b0; w_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, limit 200000 expected earlier");
    $fatal(1);
  end

  initial begin
    cyc();
    chk_on = 1'b1;
    cyc();
    @(negedge clk);
    chk("rst_w_ready", 64'(w_ready), 64'd1);
    chk("rst_bank_full", 64'(bank_full), 64'd0);
    chk("rst_vld", 64'(weight_data_vld), 64'd0);
    chk("rst_data", weight_data, 64'd0);
    rstn = 1'b1;
    cyc();

    for (int i = 1; i <= 16; i++) beat(64'(i), i == 16);
    @(negedge clk);
    chk("load_bank_full", 64'(bank_full), 64'b01);
    chk("load_w_ready", 64'(w_ready), 64'd1);
    pulse(1, 0);
    @(negedge clk);
    chk("claim_blk_words", 64'(blk_words), 64'd16);
    rd(5);
    @(negedge clk);
    chk("read5_data", weight_data, 64'h6);
    chk("read5_vld", 64'(weight_data_vld), 64'd1);

`ifdef WBUF_PARITY_EN
    dut.u_ram0.mem[2][0] = ~dut.u_ram0.mem[2][0];
    m_mem[0][2][0] = ~m_mem[0][2][0];
    m_bad_mem[0][2] = 1'b1;
`endif
    rd(2);
    @(negedge clk);
    chk("read2_data", weight_data, W3_EXP);
    cyc();
    @(negedge clk);
    chk("parity_err", 64'(parity_err), 64'(PERR_EXP));

    for (int i = 0; i < 8; i++) begin
      w_data = 64'h100 + 64'(i); w_valid = 1'b1; w_last = (i == 7);
      weight_addr = AW'(i); w_addr_vld = 1'b1;
      cyc();
    end
    w_valid = 1'b0; w_last = 1'b0; w_addr_vld = 1'b0;
    @(negedge clk);
    chk("overlap_bank_full", 64'(bank_full), 64'b11);
    chk("overlap_w_ready", 64'(w_ready), 64'd0);
    chk("overlap_read7", weight_data, 64'h8);
    pulse(0, 1);
    @(negedge clk);
    chk("done_rd_bank", 64'(rd_bank), 64'd1);
    chk("done_bank_full", 64'(bank_full), 64'b10);
    chk("done_w_ready", 64'(w_ready), 64'd1);
    pulse(0, 1);
    rd(0);
    @(negedge clk);
    chk("noread_vld", 64'(weight_data_vld), 64'd0);
    chk("ign_done_rd_bank", 64'(rd_bank), 64'd1);

    pulse(1, 0);
    @(negedge clk);
    chk("claim1_blk_words", 64'(blk_words), 64'd8);
    rd(3);
    @(negedge clk);
    chk("read_b1_3", weight_data, 64'h103);
    for (int i = 0; i < 4; i++) beat(64'h200 + 64'(i), i == 3);
    pulse(1, 1);
    @(negedge clk);
    chk("swap_rd_bank", 64'(rd_bank), 64'd0);
    chk("swap_bank_full", 64'(bank_full), 64'b01);
    chk("swap_blk_words", 64'(blk_words), 64'd4);
    rd(1);
    @(negedge clk);
    chk("read_b0_1", weight_data, 64'h201);
    pulse(0, 1);
    pulse(1, 0);
    rd(0);
    @(negedge clk);
    chk("ign_conv_rd_bank", 64'(rd_bank), 64'd1);
    chk("ign_conv_vld", 64'(weight_data_vld), 64'd0);
    chk("ign_conv_blk", 64'(blk_words), 64'd4);
    pulse(0, 1);

    beat(64'hAA, 0);
    beat(64'hBB, 0);
    rstn = 1'b0;
    cyc();
    rstn = 1'b1;
    @(negedge clk);
    chk("midrst_bank_full", 64'(bank_full), 64'd0);
    chk("midrst_parity", 64'(parity_err), 64'd0);
    cyc();

    for (int i = 1; i <= 17; i++) beat(64'h300 + 64'(i), 0);
    @(negedge clk);
    chk("ovf_err", 64'(ovf_err), 64'd1);
    chk("ovf_bank_full", 64'(bank_full), 64'b01);
    pulse(1, 0);
    @(negedge clk);
    chk("ovf_blk_words", 64'(blk_words), 64'd16);
    rd(15);
    @(negedge clk);
    chk("ovf_read15", weight_data, 64'h310);
    beat(64'h400, 0);
    beat(64'h401, 1);
    pulse(0, 1);
    pulse(1, 0);
    @(negedge clk);
    chk("ovf_b1_blk_words", 64'(blk_words), 64'd3);
    rd(0);
    @(negedge clk);
    chk("ovf_b1_word0", weight_data, 64'h311);
    rd(2);
    @(negedge clk);
    chk("ovf_b1_word2", weight_data, 64'h401);
    chk("ovf_sticky", 64'(ovf_err), 64'd1);
    repeat (3) cyc();
    chk_on = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
